// File: rtl/viterbi_tb_scheduler.sv
// Survivor-memory sequencer for the 4-state Viterbi decoder: fills a circular RAM, runs sliding-window
// traceback and streams decoded bits oldest-first. Optional VITERBI_TB_STATS_EN adds a window counter.
module viterbi_tb_scheduler #(
   parameter int AW       = 5,
   parameter int TB_DEPTH = 16,
   parameter int DEC_LEN  = 8
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_sv_valid,
   output logic          o_sv_ready,
   input  logic [7:0]    i_sv_word,
   input  logic [1:0]    i_best_state,
   input  logic          i_flush,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_waddr,
   output logic [7:0]    o_mem_wdata,
   output logic [AW-1:0] o_mem_raddr,
   input  logic [7:0]    i_mem_rdata,
   output logic          o_bit_valid,
   input  logic          i_bit_ready,
   output logic          o_bit_out,
   output logic          o_busy,
   output logic          o_flush_done
`ifdef VITERBI_TB_STATS_EN
   ,
   output logic [15:0]   o_win_count
`endif
);
   localparam int WIN = TB_DEPTH + DEC_LEN;
   localparam int CW  = AW + 1;

   typedef enum logic [1:0] {FILL, TRACE, EMIT} state_t;
   state_t r_state, w_next;

   logic [AW-1:0]  r_wptr;
   logic [CW-1:0]  r_count, r_step, r_ndec, r_nskip;
   logic [1:0]     r_s, r_start;
   logic [WIN-1:0] r_buf;
   logic           r_from_flush;

   logic          w_xfer, w_win, w_flush, w_flush_go, w_trace_last, w_accept, w_emit_last;
   logic [1:0]    w_pred;
   logic [CW-1:0] w_total;

   // Reset level gates the transfer so nothing is written while reset is held.
   assign w_xfer       = i_reset && (r_state == FILL) && i_sv_valid;
   assign w_win        = w_xfer && (r_count == CW'(WIN - 1));
   assign w_flush      = i_reset && (r_state == FILL) && i_flush && !w_xfer;
   assign w_flush_go   = w_flush && (r_count != '0);
   assign w_total      = r_nskip + r_ndec;
   assign w_trace_last = (r_state == TRACE) && (r_step == w_total);
   assign w_accept     = (r_state == EMIT) && i_bit_ready;
   assign w_emit_last  = w_accept && (r_step == r_ndec - CW'(1));

   always_comb begin
      case (r_s)
         2'd0:    w_pred = i_mem_rdata[7:6];
         2'd1:    w_pred = i_mem_rdata[5:4];
         2'd2:    w_pred = i_mem_rdata[3:2];
         default: w_pred = i_mem_rdata[1:0];
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= FILL;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      o_sv_ready   = (r_state == FILL);
      o_busy       = (r_state == TRACE) || (r_state == EMIT);
      o_bit_valid  = (r_state == EMIT);
      o_bit_out    = (r_state == EMIT) ? r_buf[0] : 1'b0;
      o_mem_we     = w_xfer;
      o_mem_waddr  = w_xfer ? r_wptr : '0;
      o_mem_wdata  = w_xfer ? i_sv_word : 8'h00;
      o_mem_raddr  = (r_state == TRACE) ? (r_wptr - AW'(1) - r_step[AW-1:0]) : '0;
      o_flush_done = (w_flush && (r_count == '0)) || (w_emit_last && r_from_flush);
      case (r_state)
         FILL:    if (w_win || w_flush_go) w_next = TRACE;
         TRACE:   if (w_trace_last) w_next = EMIT;
         EMIT:    if (w_emit_last) w_next = FILL;
         default: w_next = FILL;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_wptr       <= '0;
         r_count      <= '0;
         r_s          <= '0;
         r_start      <= '0;
         r_step       <= '0;
         r_ndec       <= '0;
         r_nskip      <= '0;
         r_buf        <= '0;
         r_from_flush <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_wptr  <= r_wptr + AW'(1);
            r_count <= r_count + CW'(1);
            r_start <= i_best_state;
         end
         if (w_win) begin
            r_nskip      <= CW'(TB_DEPTH);
            r_ndec       <= CW'(DEC_LEN);
            r_s          <= i_best_state;
            r_step       <= '0;
            r_buf        <= '0;
            r_from_flush <= 1'b0;
         end
         // Flush decodes everything still held, starting from the newest step's best state.
         if (w_flush_go) begin
            r_nskip      <= '0;
            r_ndec       <= r_count;
            r_s          <= r_start;
            r_step       <= '0;
            r_buf        <= '0;
            r_from_flush <= 1'b1;
         end
         if (r_state == TRACE) begin
            // Step k consumes the word read at step k-1 (one-cycle RAM latency).
            if (r_step != '0) begin
               r_s <= w_pred;
               if (r_step > r_nskip) r_buf <= {r_buf[WIN-2:0], r_s[0]};
            end
            r_step <= w_trace_last ? '0 : r_step + CW'(1);
         end
         if (w_accept) begin
            r_buf  <= r_buf >> 1;
            r_step <= r_step + CW'(1);
            if (w_emit_last) r_count <= r_from_flush ? '0 : r_count - r_ndec;
         end
      end
   end

`ifdef VITERBI_TB_STATS_EN
   logic [15:0] r_win_count;
   always_ff @(posedge i_clk) begin
      if (!i_reset)                                  r_win_count <= '0;
      else if (w_emit_last && r_win_count != 16'hFFFF) r_win_count <= r_win_count + 16'd1;
   end
   assign o_win_count = r_win_count;
`endif
endmodule

// File: tb/tb_viterbi_tb_scheduler.sv
// Randomized bench for viterbi_tb_scheduler: survivor words are built from a known state path, so
// every decoded bit must equal the LSB of the path state at that step, in step order.
module tb_viterbi_tb_scheduler;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0, sv_valid = 1'b0, flush = 1'b0, bit_ready = 1'b1;
   logic [7:0] sv_word = 8'h00;
   logic [1:0] best = 2'd0;
   logic       sv_ready, mem_we, bit_valid, bit_out, busy, flush_done;
   logic [4:0] mem_waddr, mem_raddr;
   logic [7:0] mem_wdata, rdata;
`ifdef VITERBI_TB_STATS_EN
   logic [15:0] win_count;
`endif

   viterbi_tb_scheduler #(.AW(5), .TB_DEPTH(16), .DEC_LEN(8)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_sv_valid(sv_valid), .o_sv_ready(sv_ready),
      .i_sv_word(sv_word), .i_best_state(best), .i_flush(flush),
      .o_mem_we(mem_we), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
      .o_mem_raddr(mem_raddr), .i_mem_rdata(rdata),
      .o_bit_valid(bit_valid), .i_bit_ready(bit_ready), .o_bit_out(bit_out),
      .o_busy(busy), .o_flush_done(flush_done)
`ifdef VITERBI_TB_STATS_EN
      , .o_win_count(win_count)
`endif
   );

   always #5 clk = ~clk;

   logic [7:0] ram [0:31];
   always @(posedge clk) begin
      if (mem_we) ram[mem_waddr] <= mem_wdata;
      rdata <= ram[mem_raddr];
   end

   int   n_chk = 0, n_pass = 0;
   bit   exp_q[$];
   int   exp_waddr = 0, n_bits = 0, n_pulse = 0, rdy_mode = 0;
   logic prev_stall = 1'b0, prev_bit = 1'b0;
   logic [1:0] cur = 2'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   // Monitor: write addresses, accepted bits against the path model, stall stability.
   always @(negedge clk) begin
      if (!rst_n) prev_stall = 1'b0;
      else begin
         if (mem_we) begin
            chk("waddr", 32'(mem_waddr), 32'(exp_waddr));
            chk("wdata", 32'(mem_wdata), 32'(sv_word));
            exp_waddr = (exp_waddr + 1) % 32;
         end
         if (prev_stall && bit_valid) chk("stall_hold", 32'(bit_out), 32'(prev_bit));
         if (bit_valid && bit_ready) begin
            if (exp_q.size() == 0) chk("extra_bit", 32'(exp_q.size()), 1);
            else chk("bit", 32'(bit_out), 32'(exp_q.pop_front()));
            n_bits++;
         end
         if (flush_done) n_pulse++;
         prev_stall = bit_valid && !bit_ready;
         prev_bit   = bit_out;
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       bit_ready = 1'b1;
            1:       bit_ready = ~bit_ready;
            default: bit_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic do_reset;
      rst_n = 1'b0; sv_valid = 1'b1; sv_word = 8'hA5; flush = 1'b0;
      repeat (2) begin
         tick;
         chk("rst_rdy", 32'(sv_ready), 1);
         chk("rst_we", 32'(mem_we), 0);
         chk("rst_waddr", 32'(mem_waddr), 0);
         chk("rst_wdata", 32'(mem_wdata), 0);
         chk("rst_raddr", 32'(mem_raddr), 0);
         chk("rst_valid", 32'(bit_valid), 0);
         chk("rst_out", 32'(bit_out), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_fdone", 32'(flush_done), 0);
      end
      sv_valid = 1'b0; exp_q.delete();
      exp_waddr = 0; n_bits = 0; n_pulse = 0; cur = 2'd0;
      rst_n = 1'b1;
   endtask

   // Survivor word for a step into state ns: its field points back to the current state.
   task automatic send(input logic [1:0] ns, input bit zero);
      logic [7:0] w;
      int pos, n;
      w   = zero ? 8'h00 : 8'($urandom);
      pos = (3 - int'(ns)) * 2;
      w[pos +: 2] = cur;
      sv_valid = 1'b1; sv_word = w; best = ns;
      n = 0;
      while (!sv_ready && n < 500) begin tick; n++; end
      if (n >= 500) chk("send_timeout", 32'(sv_ready), 1);
      tick;
      exp_q.push_back(ns[0]);
      cur = ns;
      sv_valid = 1'b0;
   endtask

   task automatic wait_fill(output int n);
      n = 0;
      while (!sv_ready && n < 2000) begin tick; n++; end
      if (n >= 2000) chk("fill_timeout", 32'(sv_ready), 1);
   endtask

   int n, m;
   logic [1:0] path [4] = '{2'd1, 2'd3, 2'd2, 2'd0};

   initial begin
      do_reset;

      // All-zero survivors: 25-cycle trace, 33 cycles trigger to FILL, 8 bits out.
      rdy_mode = 0;
      repeat (24) send(2'd0, 1'b1);
      n = 0;
      while (!bit_valid && n < 100) begin tick; n++; end
      chk("trace_len", 32'(n), 25);
      wait_fill(m);
      chk("win_len", 32'(n + m), 33);
      chk("win_bits", 32'(n_bits), 8);
      chk("held_steps", 32'(exp_q.size()), 16);

      // Known path 1,3,2,0,...
      for (int i = 0; i < 24; i++) send(path[i % 4], 1'b0);
      wait_fill(n);
      chk("path_bits", 32'(n_bits), 32);

      // Back-pressure with alternating ready.
      rdy_mode = 1;
      for (int i = 0; i < 8; i++) send(2'($urandom), 1'b0);
      wait_fill(n);
      chk("bp_bits", 32'(n_bits), 40);
      chk("bp_held", 32'(exp_q.size()), 16);

      // Wrap-around over 100 words, random ready, then flush the tail.
      do_reset;
      rdy_mode = 2;
      for (int i = 0; i < 100; i++) send(2'($urandom), 1'b0);
      wait_fill(n);
      chk("wrap_ptr", 32'(exp_waddr), 4);
      flush = 1'b1; tick; flush = 1'b0;
      wait_fill(n);
      chk("drain_empty", 32'(exp_q.size()), 0);
      chk("drain_bits", 32'(n_bits), 100);
      chk("drain_pulse", 32'(n_pulse), 1);

      // Short flush, then an empty flush, then a full window from count 0.
      do_reset;
      rdy_mode = 0;
      for (int i = 0; i < 5; i++) send(2'($urandom), 1'b0);
      flush = 1'b1; tick; flush = 1'b0;
      wait_fill(n);
      chk("flush_bits", 32'(n_bits), 5);
      chk("flush_pulse", 32'(n_pulse), 1);
      flush = 1'b1; tick; flush = 1'b0;
      repeat (3) tick;
      chk("flush2_pulse", 32'(n_pulse), 2);
      chk("flush2_bits", 32'(n_bits), 5);
      chk("flush2_busy", 32'(busy), 0);
      for (int i = 0; i < 23; i++) send(2'($urandom), 1'b0);
      chk("pre_win_busy", 32'(busy), 0);
      send(2'($urandom), 1'b0);
      chk("win_busy", 32'(busy), 1);
      wait_fill(n);
      chk("post_flush_win", 32'(n_bits), 13);
`ifdef VITERBI_TB_STATS_EN
      chk("win_count", 32'(win_count), 2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/viterbi_tb_scheduler.md
# viterbi_tb_scheduler

Sequencing controller for the survivor memory of the 4-state, rate-1/2 Viterbi decoder. Accepts one survivor word per trellis step from the add-compare-select stage and writes it into an external circular survivor RAM. Once enough steps are stored, it schedules a sliding-window traceback through the RAM and streams the decoded bits out oldest-first over a valid/ready handshake. It replaces the free-running dual-clock traceback with a single-clock, back-pressured schedule.

## Interface
Parameters:
- AW, 5, survivor RAM address width; depth 2^AW words
- TB_DEPTH, 16, convergence steps traced and discarded before decoding
- DEC_LEN, 8, bits decoded per window; TB_DEPTH+DEC_LEN <= 2^AW

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- sv_valid  in  1  survivor word valid
- sv_ready  out  1  high only in FILL
- sv_word  in  8  predecessors: [7:6] state0, [5:4] state1, [3:2] state2, [1:0] state3
- best_state  in  2  minimum-metric state at this step
- flush  in  1  end-of-frame request, level, sampled in FILL
- mem_we  out  1  survivor RAM write strobe
- mem_waddr  out  AW  write address
- mem_wdata  out  8  write data (= sv_word)
- mem_raddr  out  AW  read address; RAM returns mem_rdata one cycle later
- mem_rdata  in  8  read data
- bit_valid  out  1  decoded bit valid
- bit_ready  in  1  downstream accept
- bit_out  out  1  decoded bit
- busy  out  1  high in TRACE or EMIT
- flush_done  out  1  one-cycle pulse when a flush completes

## Operation
- Registers: wptr (AW bits), count (AW+1 bits), trace state s (2 bits), step counter, shift buffer of TB_DEPTH+DEC_LEN bits, ndec and nskip.
- FILL: a transfer occurs when sv_valid && sv_ready. On a transfer, mem_we=1, mem_waddr=wptr, mem_wdata=sv_word. Then wptr++ (wraps mod 2^AW) and count++. The best_state of the transfer is latched as the start state.
- Window trigger: when a transfer makes count = TB_DEPTH+DEC_LEN, set nskip=TB_DEPTH and ndec=DEC_LEN, then go to TRACE.
- Flush trigger: flush=1 in FILL with no transfer in that cycle.
  - If count=0: pulse flush_done and stay in FILL.
  - Otherwise set nskip=0, ndec=count, and go to TRACE.
  - Transfer has priority over flush in the same cycle.
- TRACE: read addresses wptr-1, wptr-2, … (wrapping), one per cycle, nskip+ndec reads in total.
  - For each returned word, bit = s[0], then s <= the field of mem_rdata selected by s.
  - The first nskip bits are discarded. The next ndec bits shift into the buffer, newest-last-in, so the oldest bit ends up at the read head.
  - After the last read, go to EMIT.
- EMIT: present buffered bits oldest-first on bit_out, with bit_valid=1. Advance on bit_valid && bit_ready. bit_out is held stable while stalled.
  - After ndec accepted bits: count <= count-ndec and return to FILL.
  - If the window came from a flush, count <= 0, wptr is unchanged, and flush_done pulses.
- Every decoded bit is emitted exactly once across consecutive windows. Windows overlap by TB_DEPTH steps.

## Timing
- Reset (reset=0 at clk edge) returns to FILL:
  - wptr=0, count=0, s=0.
  - sv_ready=1, mem_we=0, mem_waddr=0, mem_wdata=0, mem_raddr=0.
  - bit_valid=0, bit_out=0, busy=0, flush_done=0.
- Reset mid-TRACE or mid-EMIT abandons the window. Pending bits are lost.
- mem_we, mem_waddr and mem_wdata are combinational from the transfer in FILL.
- TRACE lasts nskip+ndec+1 cycles, because of the one-cycle RAM read latency.
- First bit_valid appears the cycle after TRACE ends.
- Full window with bit_ready tied high: trigger to return-to-FILL takes TB_DEPTH+DEC_LEN+1+DEC_LEN cycles.
- sv_ready=0 throughout TRACE and EMIT. No survivor word is dropped.
- count never exceeds TB_DEPTH+DEC_LEN. Writes never overwrite unread survivors.

## Configuration
- VITERBI_TB_STATS_EN defined:
  - Adds output port win_count (16 bits), reset to 0.
  - Increments once per completed EMIT (window or flush) and saturates at 16'hFFFF.
- Not defined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Reset: hold reset=0 for 2 cycles with sv_valid=1 -> all outputs at their reset values, no mem_we; the first transfer after release writes address 0.
- All-zero survivors: feed 24 words of 8'h00, best_state=0 -> TRACE for 25 cycles, then 8 bits of 0 emitted; sv_ready returns to 1 with count=16.
- Known path: survivor words encoding state sequence 1,3,2,0,… with matching best_state -> emitted bits equal the LSB of each state, oldest first, matching the golden model.
- Back-pressure: toggle bit_ready 1010… during EMIT -> bit_out stable while stalled; exactly 8 bits accepted; no duplicates or skips.
- Wrap-around: stream 100 words with AW=5 -> mem_waddr wraps 31→0; decoded stream matches the model over the whole stream.
- Flush: after 5 words, assert flush -> 5 bits emitted (nskip=0), flush_done pulses once, count=0; a second flush immediately pulses flush_done with no bits emitted.
